processor_bus_ctrl: RTL

// - Parametrised successor to the processor's single-bus transfer unit: N_SRC sources, N_DST destination registers.
// - Moves one word per request through a registered bus with a valid/ready handshake and a 3-state FSM.
// - Single clock edge throughout (no negedge phase).
// - Sits between the control unit (issues src/dst codes) and the datapath registers (AC, R1, R2, SRx, MDR, ...).

---
 rtl/processor_bus_pkg.sv | 16 +
 rtl/bus_source_mux.sv | 49 ++++
 rtl/processor_bus_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/processor_bus_pkg.sv
// Shared encodings for the processor bus transfer unit: FSM states and special source/destination codes.
package processor_bus_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;

  localparam int unsigned SRC_HOLD = 0;
  localparam int unsigned DST_NONE = 0;

  // Source code that selects the instruction immediate, one past the last word source.
  function automatic int unsigned src_imm_code(input int unsigned n);
    return n + 1;
  endfunction

endpackage

// File: rtl/bus_source_mux.sv
// Combinational source selector for the processor bus, with a code-range valid flag.
// BUS_IMM_EN enables code N_SRC+1 as the zero-extended instruction immediate.
module bus_source_mux
  import processor_bus_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned N_SRC   = 11,
  parameter int unsigned IMM_LSB = 8,
  parameter int unsigned IMM_W   = 4,
  parameter int unsigned SRC_W   = 4
) (
  input  logic [N_SRC*WIDTH-1:0] src_flat,
  input  logic [WIDTH-1:0]       instruction,
  input  logic [SRC_W-1:0]       sel,
  output logic [WIDTH-1:0]       word_c,
  output logic                   valid_c
);

`ifdef BUS_IMM_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  localparam logic [SRC_W-1:0] IMM_CODE = SRC_W'(src_imm_code(N_SRC));

  logic [WIDTH-1:0] imm_word;
  logic             unused_instr;

  assign imm_word     = WIDTH'(instruction[IMM_LSB +: IMM_W]);
  assign unused_instr = ^instruction;

  // Code 0 (hold) is valid but drives zero; the top keeps the bus unchanged for it.
  always_comb begin
    word_c  = '0;
    valid_c = 1'b0;
    if (sel <= SRC_W'(N_SRC)) begin
      valid_c = 1'b1;
    end else if (IMM_EN && (sel == IMM_CODE)) begin
      valid_c = 1'b1;
      word_c  = imm_word;
    end
    for (int k = 0; k < int'(N_SRC); k++) begin
      if (sel == SRC_W'(k + 1)) word_c = src_flat[k*WIDTH +: WIDTH];
    end
    if (sel == SRC_W'(SRC_HOLD)) word_c = '0;
  end

endmodule

// File: rtl/processor_bus_ctrl.sv
// Registered single-bus transfer unit: IDLE -> CAPTURE -> WRITE, one word per accepted request.
// BUS_IMM_EN (in bus_source_mux) enables the instruction-immediate source code.
module processor_bus_ctrl
  import processor_bus_pkg::*;
#(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      N_SRC       = 11,
  parameter int unsigned      N_DST       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(16'h0007),
  parameter int unsigned      IMM_LSB     = 8,
  parameter int unsigned      IMM_W       = 4,
  localparam int unsigned     SRC_W       = $clog2(N_SRC + 2),
  localparam int unsigned     DST_W       = $clog2(N_DST + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_SRC*WIDTH-1:0] src_flat,
  input  logic [WIDTH-1:0]       instruction,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [SRC_W-1:0]       req_src,
  input  logic [DST_W-1:0]       req_dst,
  output logic [WIDTH-1:0]       bus_out,
  output logic [N_DST*WIDTH-1:0] dst_flat,
  output logic [N_DST-1:0]       dst_we,
  output logic                   done,
  output logic                   err,
  output logic [15:0]            xfer_count
);

  logic [1:0]                  state;
  logic [1:0]                  state_d;
  logic [SRC_W-1:0]            src_q;
  logic [DST_W-1:0]            dst_q;
  logic [SRC_W-1:0]            mux_sel;
  logic [WIDTH-1:0]            mux_word_c;
  logic                        mux_valid_c;
  logic                        accept_c;
  logic                        reject_c;
  logic [N_DST-1:0][WIDTH-1:0] dst_regs;

  // In IDLE the mux range-checks the incoming code; afterwards it selects the latched one.
  assign mux_sel  = (state == ST_IDLE) ? req_src : src_q;
  assign dst_flat = dst_regs;

  bus_source_mux #(
    .WIDTH   (WIDTH),
    .N_SRC   (N_SRC),
    .IMM_LSB (IMM_LSB),
    .IMM_W   (IMM_W),
    .SRC_W   (SRC_W)
  ) u_src_mux (
    .src_flat    (src_flat),
    .instruction (instruction),
    .sel         (mux_sel),
    .word_c      (mux_word_c),
    .valid_c     (mux_valid_c)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d  = state;
    accept_c = 1'b0;
    reject_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (mux_valid_c && (req_dst <= DST_W'(N_DST))) begin
            accept_c = 1'b1;
            state_d  = ST_CAPTURE;
          end else begin
            reject_c = 1'b1;
          end
        end
      end
      ST_CAPTURE: state_d = ST_WRITE;
      ST_WRITE:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath: request latch, bus register, destination bank, status pulses and counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_ready  <= 1'b1;
      src_q      <= '0;
      dst_q      <= '0;
      bus_out    <= RESET_VALUE;
      dst_regs   <= '0;
      dst_we     <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      xfer_count <= 16'd0;
    end else begin
      req_ready <= (state_d == ST_IDLE);
      err       <= reject_c;
      dst_we    <= '0;
      done      <= 1'b0;
      if (accept_c) begin
        src_q <= req_src;
        dst_q <= req_dst;
      end
      if ((state == ST_CAPTURE) && (src_q != SRC_W'(SRC_HOLD))) begin
        bus_out <= mux_word_c;
      end
      if (state == ST_WRITE) begin
        done       <= 1'b1;
        xfer_count <= xfer_count + 16'd1;
        if (dst_q != DST_W'(DST_NONE)) begin
          for (int k = 0; k < int'(N_DST); k++) begin
            if (dst_q == DST_W'(k + 1)) begin
              dst_regs[k] <= bus_out;
              dst_we[k]   <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
